// File: rtl/cruise_speed_sequencer_if.sv
// Interface between cruise_speed_sequencer and its host. The resume_pulse
// signal exists only when CRUISE_RESUME_EN is defined.
interface cruise_speed_sequencer_if #(
   parameter int WIDTH = 3
);
   logic             cruise_on;
   logic             set_pulse;
   logic             accel_req;
   logic             brake_req;
   logic [WIDTH-1:0] speed_in;
`ifdef CRUISE_RESUME_EN
   logic             resume_pulse;
`endif
   logic             cnt_enable;
   logic             cnt_mode;
   logic [WIDTH-1:0] target;
   logic [1:0]       state;

   modport master (
      output cruise_on, set_pulse, accel_req, brake_req, speed_in,
`ifdef CRUISE_RESUME_EN
      output resume_pulse,
`endif
      input  cnt_enable, cnt_mode, target, state
   );

   modport slave (
      input  cruise_on, set_pulse, accel_req, brake_req, speed_in,
`ifdef CRUISE_RESUME_EN
      input  resume_pulse,
`endif
      output cnt_enable, cnt_mode, target, state
   );
endinterface

// File: rtl/cruise_speed_sequencer.sv
// Step sequencer for the cruise-control up/down speed counter: manual stepping,
// cruise hold toward a latched target. Define CRUISE_RESUME_EN for brake/resume.
module cruise_speed_sequencer #(
   parameter int WIDTH     = 3,
   parameter int STEP_DIV  = 4,
   parameter int MAX_SPEED = 7
) (
   input logic                    clk,
   input logic                    reset,
   cruise_speed_sequencer_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      ACCEL = 2'd2,
      DECEL = 2'd3
   } state_t;

   localparam int               PW       = $clog2(STEP_DIV);
   localparam logic [PW-1:0]    PRE_LAST = PW'(STEP_DIV - 1);
   localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_SPEED);

   function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
      return (v >= MAX_V) ? MAX_V : v + WIDTH'(1);
   endfunction

   state_t           state_cur, state_nxt;
   logic [WIDTH-1:0] target_cur, target_nxt;
   logic [PW-1:0]    prescaler;
   logic             accel_prev;
   logic             cnt_enable_p1, cnt_mode_p1;
   logic             tick, accel_edge, step_up, step_down, fire;

   assign tick       = (prescaler == PRE_LAST);
   assign accel_edge = bus.accel_req && !accel_prev;
   assign fire       = (step_up && (bus.speed_in < MAX_V)) ||
                       (step_down && (bus.speed_in != '0));

   always_comb begin
      state_nxt  = state_cur;
      target_nxt = target_cur;
      step_up    = 1'b0;
      step_down  = 1'b0;
      if (!bus.cruise_on) begin
         state_nxt  = IDLE;
         target_nxt = '0;
         if (bus.brake_req)      step_down = 1'b1;
         else if (bus.accel_req) step_up   = 1'b1;
      end else if (state_cur == IDLE) begin
         if (bus.brake_req) begin
            step_down = 1'b1;
         end else if (bus.set_pulse) begin
            target_nxt = bus.speed_in;
            state_nxt  = HOLD;
         end
`ifdef CRUISE_RESUME_EN
         else if (bus.resume_pulse && (target_cur != '0)) begin
            state_nxt = HOLD;
         end
`endif
         else if (bus.accel_req) begin
            step_up = 1'b1;
         end
      end else if (bus.brake_req) begin
         state_nxt = IDLE;
`ifndef CRUISE_RESUME_EN
         target_nxt = '0;
`endif
      end else if (bus.set_pulse) begin
         target_nxt = bus.speed_in;
         state_nxt  = HOLD;
      end else begin
         // Direction is chosen against the current target; a bump takes effect next cycle.
         if (accel_edge) target_nxt = sat_inc(target_cur);
         if (bus.speed_in < target_cur)      state_nxt = ACCEL;
         else if (bus.speed_in > target_cur) state_nxt = DECEL;
         else                                state_nxt = HOLD;
         step_up   = (state_cur == ACCEL) && (bus.speed_in < target_cur);
         step_down = (state_cur == DECEL) && (bus.speed_in > target_cur);
      end
   end

   // Stage p1: registered step strobe and direction handed to the counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_cur     <= IDLE;
         target_cur    <= '0;
         prescaler     <= '0;
         accel_prev    <= 1'b0;
         cnt_enable_p1 <= 1'b0;
         cnt_mode_p1   <= 1'b0;
      end else begin
         state_cur     <= state_nxt;
         target_cur    <= target_nxt;
         prescaler     <= tick ? '0 : prescaler + PW'(1);
         accel_prev    <= bus.accel_req;
         cnt_enable_p1 <= tick && fire;
         if (tick && fire) cnt_mode_p1 <= step_up;
      end
   end

   assign bus.cnt_enable = cnt_enable_p1;
   assign bus.cnt_mode   = cnt_mode_p1;
   assign bus.target     = target_cur;
   assign bus.state      = state_cur;
endmodule

// File: tb/tb_cruise_speed_sequencer.sv
// Directed bench for cruise_speed_sequencer with a behavioural speed counter;
// covers both builds of CRUISE_RESUME_EN.
module tb_cruise_speed_sequencer;
   logic clk = 1'b0;
   logic reset;
   int   n_run  = 0;
   int   n_fail = 0;
   int   cyc_no = 0;
   int   pulse_cnt = 0;
   logic [2:0] speed = 3'd0;

   cruise_speed_sequencer_if #(.WIDTH(3)) bus ();

   cruise_speed_sequencer #(.WIDTH(3), .STEP_DIV(4), .MAX_SPEED(7)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // One clock; the counter model applies the pulse seen before the edge.
   task automatic cyc();
      logic en, md;
      en = bus.cnt_enable;
      md = bus.cnt_mode;
      @(posedge clk);
      #1;
      cyc_no++;
      if (en === 1'b1) begin
         pulse_cnt++;
         speed = md ? speed + 3'd1 : speed - 3'd1;
      end
      bus.speed_in = speed;
   endtask

   task automatic set_speed(input logic [2:0] v);
      speed = v;
      bus.speed_in = v;
   endtask

   task automatic latch_target();
      bus.set_pulse = 1'b1;
      cyc();
      bus.set_pulse = 1'b0;
   endtask

   task automatic bump();
      bus.accel_req = 1'b1;
      cyc();
      bus.accel_req = 1'b0;
      cyc();
   endtask

   task automatic test_reset();
      int bad;
      reset = 1'b1;
      bus.cruise_on = 1'b0; bus.set_pulse = 1'b0;
      bus.accel_req = 1'b0; bus.brake_req = 1'b0;
`ifdef CRUISE_RESUME_EN
      bus.resume_pulse = 1'b0;
`endif
      set_speed(3'd0);
      cyc(); cyc();
      n_run++; if (bus.cnt_enable !== 1'b0) begin n_fail++; $display("FAIL rst_enable got %b want 0", bus.cnt_enable); end
      n_run++; if (bus.cnt_mode !== 1'b0) begin n_fail++; $display("FAIL rst_mode got %b want 0", bus.cnt_mode); end
      n_run++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL rst_state got %0d want 0", bus.state); end
      n_run++; if (bus.target !== 3'd0) begin n_fail++; $display("FAIL rst_target got %0d want 0", bus.target); end
      reset = 1'b0;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (bus.cnt_enable !== 1'b0 || bus.state !== 2'd0 || bus.target !== 3'd0) bad++;
      end
      n_run++; if (bad !== 0) begin n_fail++; $display("FAIL idle_quiet got %0d bad cycles want 0", bad); end
   endtask

   task automatic test_manual_accel();
      int p0, last, bad_gap, bad_mode, bad_bound;
      p0 = pulse_cnt; last = -1; bad_gap = 0; bad_mode = 0; bad_bound = 0;
      set_speed(3'd0);
      bus.accel_req = 1'b1;
      for (int i = 0; i < 40; i++) begin
         cyc();
         if (bus.cnt_enable === 1'b1) begin
            if (bus.cnt_mode !== 1'b1) bad_mode++;
            if (speed >= 3'd7) bad_bound++;
            if (last >= 0 && cyc_no - last != 4) bad_gap++;
            last = cyc_no;
         end
      end
      bus.accel_req = 1'b0;
      cyc();
      n_run++; if (pulse_cnt - p0 !== 7) begin n_fail++; $display("FAIL accel_pulses got %0d want 7", pulse_cnt - p0); end
      n_run++; if (speed !== 3'd7) begin n_fail++; $display("FAIL accel_speed got %0d want 7", speed); end
      n_run++; if (bad_mode !== 0) begin n_fail++; $display("FAIL accel_mode got %0d wrong pulses want 0", bad_mode); end
      n_run++; if (bad_gap !== 0) begin n_fail++; $display("FAIL accel_spacing got %0d bad gaps want 0", bad_gap); end
      n_run++; if (bad_bound !== 0) begin n_fail++; $display("FAIL accel_bound got %0d pulses at max want 0", bad_bound); end
   endtask

   task automatic test_hold_track();
      int p0;
      bus.cruise_on = 1'b1;
      set_speed(3'd3);
      latch_target();
      n_run++; if (bus.target !== 3'd3) begin n_fail++; $display("FAIL latch_target got %0d want 3", bus.target); end
      n_run++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL latch_state got %0d want 1", bus.state); end
      p0 = pulse_cnt;
      for (int i = 0; i < 10; i++) cyc();
      n_run++; if (pulse_cnt - p0 !== 0) begin n_fail++; $display("FAIL equal_nostep got %0d pulses want 0", pulse_cnt - p0); end
      set_speed(3'd1);
      cyc();
      n_run++; if (bus.state !== 2'd2) begin n_fail++; $display("FAIL enter_accel got %0d want 2", bus.state); end
      p0 = pulse_cnt;
      for (int i = 0; i < 20; i++) cyc();
      n_run++; if (pulse_cnt - p0 !== 2) begin n_fail++; $display("FAIL track_pulses got %0d want 2", pulse_cnt - p0); end
      n_run++; if (speed !== 3'd3) begin n_fail++; $display("FAIL track_speed got %0d want 3", speed); end
      n_run++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL track_hold got %0d want 1", bus.state); end
   endtask

   task automatic test_target_bump();
      int p0;
      p0 = pulse_cnt;
      bus.accel_req = 1'b1; cyc();
      bus.accel_req = 1'b0; cyc();
      bus.accel_req = 1'b1; cyc();
      bus.accel_req = 1'b0;
      n_run++; if (bus.target !== 3'd5) begin n_fail++; $display("FAIL bump_target got %0d want 5", bus.target); end
      n_run++; if (bus.state !== 2'd2) begin n_fail++; $display("FAIL bump_state got %0d want 2", bus.state); end
      for (int i = 0; i < 30; i++) cyc();
      n_run++; if (pulse_cnt - p0 !== 2) begin n_fail++; $display("FAIL bump_pulses got %0d want 2", pulse_cnt - p0); end
      n_run++; if (speed !== 3'd5) begin n_fail++; $display("FAIL bump_speed got %0d want 5", speed); end
      n_run++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL bump_hold got %0d want 1", bus.state); end
   endtask

   task automatic test_brake();
      int p0, last, bad_gap, bad_mode;
      bus.brake_req = 1'b1;
      cyc();
      n_run++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL brake_state got %0d want 0", bus.state); end
`ifdef CRUISE_RESUME_EN
      n_run++; if (bus.target !== 3'd5) begin n_fail++; $display("FAIL brake_keep got %0d want 5", bus.target); end
`else
      n_run++; if (bus.target !== 3'd0) begin n_fail++; $display("FAIL brake_clear got %0d want 0", bus.target); end
`endif
      p0 = pulse_cnt; last = -1; bad_gap = 0; bad_mode = 0;
      for (int i = 0; i < 28; i++) begin
         cyc();
         if (bus.cnt_enable === 1'b1) begin
            if (bus.cnt_mode !== 1'b0) bad_mode++;
            if (last >= 0 && cyc_no - last != 4) bad_gap++;
            last = cyc_no;
         end
      end
      bus.brake_req = 1'b0;
      n_run++; if (pulse_cnt - p0 !== 5) begin n_fail++; $display("FAIL brake_pulses got %0d want 5", pulse_cnt - p0); end
      n_run++; if (speed !== 3'd0) begin n_fail++; $display("FAIL brake_floor got %0d want 0", speed); end
      n_run++; if (bad_mode !== 0) begin n_fail++; $display("FAIL brake_mode got %0d wrong pulses want 0", bad_mode); end
      n_run++; if (bad_gap !== 0) begin n_fail++; $display("FAIL brake_spacing got %0d bad gaps want 0", bad_gap); end
`ifdef CRUISE_RESUME_EN
      bus.resume_pulse = 1'b1;
      cyc();
      bus.resume_pulse = 1'b0;
      n_run++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL resume_state got %0d want 1", bus.state); end
      n_run++; if (bus.target !== 3'd5) begin n_fail++; $display("FAIL resume_target got %0d want 5", bus.target); end
      for (int i = 0; i < 40; i++) cyc();
      n_run++; if (speed !== 3'd5) begin n_fail++; $display("FAIL resume_speed got %0d want 5", speed); end
      n_run++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL resume_hold got %0d want 1", bus.state); end
`endif
   endtask

   task automatic test_saturate();
      set_speed(3'd6);
      latch_target();
      n_run++; if (bus.target !== 3'd6) begin n_fail++; $display("FAIL sat_latch got %0d want 6", bus.target); end
      bump();
      n_run++; if (bus.target !== 3'd7) begin n_fail++; $display("FAIL sat_first got %0d want 7", bus.target); end
      bump();
      bump();
      n_run++; if (bus.target !== 3'd7) begin n_fail++; $display("FAIL sat_hold got %0d want 7", bus.target); end
      for (int i = 0; i < 10; i++) cyc();
      n_run++; if (speed !== 3'd7) begin n_fail++; $display("FAIL sat_speed got %0d want 7", speed); end
   endtask

   task automatic test_reset_mid();
      logic seen;
      set_speed(3'd0);
      latch_target();
      for (int i = 0; i < 5; i++) bump();
      n_run++; if (bus.target !== 3'd5) begin n_fail++; $display("FAIL mid_target got %0d want 5", bus.target); end
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         cyc();
         if (bus.cnt_enable === 1'b1) seen = 1'b1;
      end
      n_run++; if (seen !== 1'b1) begin n_fail++; $display("FAIL mid_timeout got no pulse want pulse within 20 cycles"); end
      // Land the reset on the next prescaler tick, when another step is due.
      cyc(); cyc(); cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      n_run++; if (bus.cnt_enable !== 1'b0) begin n_fail++; $display("FAIL mid_enable got %b want 0", bus.cnt_enable); end
      n_run++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL mid_state got %0d want 0", bus.state); end
      n_run++; if (bus.target !== 3'd0) begin n_fail++; $display("FAIL mid_clear got %0d want 0", bus.target); end
   endtask

   task automatic test_cruise_off();
      set_speed(3'd5);
      latch_target();
      set_speed(3'd7);
      cyc();
      n_run++; if (bus.state !== 2'd3) begin n_fail++; $display("FAIL off_decel got %0d want 3", bus.state); end
      bus.cruise_on = 1'b0;
      cyc();
      n_run++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL off_state got %0d want 0", bus.state); end
      n_run++; if (bus.target !== 3'd0) begin n_fail++; $display("FAIL off_target got %0d want 0", bus.target); end
   endtask

   initial begin
      test_reset();
      test_manual_accel();
      test_hold_track();
      test_target_bump();
      test_brake();
      test_saturate();
      test_reset_mid();
      test_cruise_off();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
